// File: rtl/hdmi_timing_gen_if.sv
// Raster timing bundle between the timing generator and the display stages.
// Carries the run request into the generator and the aligned x/y/sync/de/strobe outputs back.
// master = generator side (drives timing, samples enable); slave = consumer side.
interface hdmi_timing_gen_if #(
    parameter int HBW = 12,
    parameter int VBW = 11
);
    logic           enable;
    logic [HBW-1:0] x;
    logic [VBW-1:0] y;
    logic           hsync;
    logic           vsync;
    logic           de;
    logic           line_start;
    logic           frame_start;
    logic [15:0]    frame_count;

    modport master (
        input  enable,
        output x, y, hsync, vsync, de, line_start, frame_start, frame_count
    );

    modport slave (
        output enable,
        input  x, y, hsync, vsync, de, line_start, frame_start, frame_count
    );
endinterface

// File: rtl/hdmi_timing_gen.sv
// Raster timing generator: pixel x/y counters plus hsync/vsync/de and line/frame strobes.
// Latency: every output is registered and aligned to the same (x, y); one edge from enable to first pixel.
// No backpressure: free-runs one pixel per clock; enable is only honoured in IDLE and on a frame's last pixel.
// Ports: clock (pixel clock), reset (async, active-high), tim (hdmi_timing_gen_if.master).
module hdmi_timing_gen #(
    parameter int   H_ACTIVE = 1920,
    parameter int   H_FP     = 88,
    parameter int   H_SYNC   = 44,
    parameter int   H_BP     = 148,
    parameter int   V_ACTIVE = 1080,
    parameter int   V_FP     = 4,
    parameter int   V_SYNC   = 5,
    parameter int   V_BP     = 36,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1,
    parameter int   HBW      = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int   VBW      = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic              clock,
    input  logic              reset,
    hdmi_timing_gen_if.master tim
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Boundaries sized to the counters so every compare is width-matched.
    localparam logic [HBW-1:0] X_LAST  = HBW'(H_TOTAL - 1);
    localparam logic [HBW-1:0] X_ACT   = HBW'(H_ACTIVE);
    localparam logic [HBW-1:0] HS_BEG  = HBW'(H_ACTIVE + H_FP);
    localparam logic [HBW-1:0] HS_END  = HBW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VBW-1:0] Y_LAST  = VBW'(V_TOTAL - 1);
    localparam logic [VBW-1:0] Y_ACT   = VBW'(V_ACTIVE);
    localparam logic [VBW-1:0] VS_BEG  = VBW'(V_ACTIVE + V_FP);
    localparam logic [VBW-1:0] VS_END  = VBW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [HBW-1:0] x_q, x_d;
    logic [VBW-1:0] y_q, y_d;
    logic [15:0]    frame_count_q, frame_count_d;
    logic           hsync_q, vsync_q, de_q, line_start_q, frame_start_q;
    logic           run_d;
    logic           last_px;

    assign last_px = (x_q == X_LAST) && (y_q == Y_LAST);

    // Next coordinate/state. Outputs are then derived from the *next* coordinate
    // so that every registered output describes the same pixel as x_q/y_q.
    always_comb begin
        state_d       = state_q;
        x_d           = '0;
        y_d           = '0;
        frame_count_d = frame_count_q;
        case (state_q)
            ST_IDLE: begin
                if (tim.enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (x_q == X_LAST) begin
                    x_d = '0;
                    y_d = (y_q == Y_LAST) ? '0 : y_q + VBW'(1);
                end else begin
                    x_d = x_q + HBW'(1);
                    y_d = y_q;
                end
                // Frame boundary: the only point where a stop request is honoured.
                if (last_px) begin
                    frame_count_d = frame_count_q + 16'd1;
                    if (!tim.enable) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign run_d = (state_d == ST_RUN);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            x_q           <= '0;
            y_q           <= '0;
            frame_count_q <= '0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            de_q          <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            frame_count_q <= frame_count_d;
            de_q          <= run_d && (x_d < X_ACT) && (y_d < Y_ACT);
            hsync_q       <= (run_d && (x_d >= HS_BEG) && (x_d < HS_END)) ? HS_POL : ~HS_POL;
            // vsync depends on y only, so it switches at x==0 and spans whole lines.
            vsync_q       <= (run_d && (y_d >= VS_BEG) && (y_d < VS_END)) ? VS_POL : ~VS_POL;
            line_start_q  <= run_d && (x_d == '0);
            frame_start_q <= run_d && (x_d == '0) && (y_d == '0);
        end
    end

    assign tim.x           = x_q;
    assign tim.y           = y_q;
    assign tim.hsync       = hsync_q;
    assign tim.vsync       = vsync_q;
    assign tim.de          = de_q;
    assign tim.line_start  = line_start_q;
    assign tim.frame_start = frame_start_q;
    assign tim.frame_count = frame_count_q;

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Directed bench for hdmi_timing_gen with a reduced raster: H 8/2/2/2 (14), V 4/1/1/1 (7).
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// Expected values are hand-derived constants and a small x/y walk from the raster definition.
module tb_hdmi_timing_gen;

    localparam int HBW = 4;
    localparam int VBW = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;

    hdmi_timing_gen_if #(.HBW(HBW), .VBW(VBW)) tim ();

    hdmi_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1),
        .HBW(HBW), .VBW(VBW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .tim   (tim)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle(input string tag, input int fc);
        check({tag, ".x"},  32'(tim.x), 0);
        check({tag, ".y"},  32'(tim.y), 0);
        check({tag, ".de"}, 32'(tim.de), 0);
        check({tag, ".hs"}, 32'(tim.hsync), 0);
        check({tag, ".vs"}, 32'(tim.vsync), 0);
        check({tag, ".ls"}, 32'(tim.line_start), 0);
        check({tag, ".fs"}, 32'(tim.frame_start), 0);
        check({tag, ".fc"}, 32'(tim.frame_count), 32'(fc));
    endtask

    // Reference outputs for pixel (ex, ey) of the 14x7 raster.
    task automatic check_px(input int ex, input int ey);
        check("px.x",  32'(tim.x), 32'(ex));
        check("px.y",  32'(tim.y), 32'(ey));
        check("px.de", 32'(tim.de), 32'((ex < 8) && (ey < 4)));
        check("px.hs", 32'(tim.hsync), 32'((ex >= 10) && (ex < 12)));
        check("px.vs", 32'(tim.vsync), 32'(ey == 5));
        check("px.ls", 32'(tim.line_start), 32'(ex == 0));
        check("px.fs", 32'(tim.frame_start), 32'((ex == 0) && (ey == 0)));
    endtask

    initial begin
        int n;
        int de_cnt, hs_cnt, vs_cnt, de_line0;

        tim.enable = 1'b0;

        // Reset held, then idle with enable low.
        #23;
        check_idle("in_reset", 0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check_idle("idle", 0);
        end

        // Start: one edge to the first active pixel, then a full walk of frame 0.
        tim.enable = 1'b1;
        de_cnt = 0; hs_cnt = 0; vs_cnt = 0; de_line0 = 0;
        for (int k = 0; k < 98; k++) begin
            step();
            check_px(k % 14, k / 14);
            de_cnt += int'(tim.de);
            hs_cnt += int'(tim.hsync);
            vs_cnt += int'(tim.vsync);
            if (k < 14) de_line0 += int'(tim.de);
        end
        check("de_line0",   32'(de_line0), 8);
        check("de_frame",   32'(de_cnt), 32);
        check("hs_frame",   32'(hs_cnt), 14);
        check("vs_frame",   32'(vs_cnt), 14);
        check("fc_in_f0",   32'(tim.frame_count), 0);

        // Back-to-back frame: no gap, count incremented.
        step();
        check_px(0, 0);
        check("fc_after_f0", 32'(tim.frame_count), 1);

        n = 0;
        do begin
            step();
            n++;
        end while (!tim.frame_start && n < 200);
        check("frame_period", 32'(n), 98);
        check("fc_after_f1",  32'(tim.frame_count), 2);

        // Drop enable mid-frame at (3,2): frame must still complete.
        n = 0;
        while (!(tim.x == 4'd3 && tim.y == 3'd2) && n < 200) begin
            step();
            n++;
        end
        check("reach_drop_x", 32'(tim.x), 3);
        check("reach_drop_y", 32'(tim.y), 2);
        tim.enable = 1'b0;
        n = 0;
        while (!(tim.x == 4'd13 && tim.y == 3'd6) && n < 200) begin
            step();
            n++;
        end
        check("drop_run_len", 32'(n), 66);
        check("fc_last_px",   32'(tim.frame_count), 2);
        step();
        check_idle("stopped", 3);
        for (int i = 0; i < 5; i++) begin
            step();
            check_idle("stay_idle", 3);
        end

        // Asynchronous reset mid-frame at (6,1).
        tim.enable = 1'b1;
        step();
        check_px(0, 0);
        n = 0;
        while (!(tim.x == 4'd6 && tim.y == 3'd1) && n < 200) begin
            step();
            n++;
        end
        check("reach_rst_pt", 32'(n), 20);
        #2;
        reset = 1'b1;
        #1;
        check_idle("async_rst", 0);
        step();
        check_idle("rst_over_edge", 0);
        reset = 1'b0;
        step();
        check_px(0, 0);
        check("fc_after_rst", 32'(tim.frame_count), 0);

        // Counter wrap: preload to 16'hFFFF mid-frame, next completed frame wraps to 0.
        step();
        force dut.frame_count_q = 16'hFFFF;
        #1;
        release dut.frame_count_q;
        n = 0;
        while (!tim.frame_start && n < 200) begin
            step();
            n++;
        end
        check("wrap_period", 32'(n), 97);
        check("fc_wrap",     32'(tim.frame_count), 0);
        n = 0;
        do begin
            step();
            n++;
        end while (!tim.frame_start && n < 200);
        check("fc_post_wrap", 32'(tim.frame_count), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
